// File: rtl/nv_ram_pkg.sv
// Shared types for the parametrised read/write-split RAM model.
// Holds the clear-sequencer state encoding and the power-down bus width.
package nv_ram_pkg;

    localparam int NV_RAM_PD_W = 32;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } nv_ram_state_e;

    function automatic logic nv_ram_is_busy(input nv_ram_state_e st);
        return (st != READY);
    endfunction

endpackage

// File: rtl/nv_ram_clr_ctl.sv
// Post-reset clear sequencer: walks every address once, writing the init word,
// then parks in READY until the next reset.
module nv_ram_clr_ctl
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    nv_ram_state_e state_r;
    nv_ram_state_e state_nx_s;
    logic [AW-1:0] clr_addr_r;
    logic [AW-1:0] clr_addr_nx_s;
    logic          clr_we_s;
    logic          busy_r;

    // Next-state and clear-write decode; the first cycle out of reset already writes address 0.
    always_comb begin
        state_nx_s    = state_r;
        clr_addr_nx_s = clr_addr_r;
        clr_we_s      = 1'b0;
        case (state_r)
            RESET: begin
                if (rstn) begin
                    clr_we_s      = 1'b1;
                    clr_addr_nx_s = clr_addr_r + AW'(1);
                    state_nx_s    = CLEAR;
                end else begin
                    state_nx_s    = RESET;
                end
            end
            CLEAR: begin
                clr_we_s = 1'b1;
                if (clr_addr_r == LAST_ADDR) begin
                    clr_addr_nx_s = {AW{1'b0}};
                    state_nx_s    = READY;
                end else begin
                    clr_addr_nx_s = clr_addr_r + AW'(1);
                end
            end
            READY: begin
                state_nx_s = READY;
            end
            default: begin
                state_nx_s    = RESET;
                clr_addr_nx_s = {AW{1'b0}};
            end
        endcase
    end

    // State, address counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= RESET;
            clr_addr_r <= {AW{1'b0}};
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            clr_addr_r <= clr_addr_nx_s;
            busy_r     <= nv_ram_is_busy(state_nx_s);
        end
    end

    assign busy     = busy_r;
    assign clr_we   = clr_we_s;
    assign clr_addr = clr_addr_r;

endmodule

// File: rtl/nv_ram_rws_param.sv
// Parametrised 1R1W synchronous RAM with post-reset clear, read-valid strobe and
// an optional output register enabled by NV_RAM_RWS_PARAM_OUTREG_EN.
module nv_ram_rws_param
    import nv_ram_pkg::*;
#(
    parameter int          DW         = 18,
    parameter int          DEPTH      = 64,
    parameter int          AW         = $clog2(DEPTH),
    parameter logic [DW-1:0] INIT_VALUE = {DW{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [AW-1:0]          ra,
    input  logic                   re,
    output logic [DW-1:0]          dout,
    output logic                   dout_vld,
    input  logic [AW-1:0]          wa,
    input  logic                   we,
    input  logic [DW-1:0]          di,
    output logic                   busy,
    input  logic [NV_RAM_PD_W-1:0] pwrbus_ram_pd
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];

    logic          busy_s;
    logic          clr_we_s;
    logic [AW-1:0] clr_addr_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic          rd_acc_s;
    logic [DW-1:0] rd_data_s;
    logic [AW-1:0] ra_d_r;
    logic          dout_vld_r;
    logic          unused_pd_s;

    assign unused_pd_s = ^pwrbus_ram_pd;

    nv_ram_clr_ctl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_ctl (
        .clk      (clk),
        .rstn     (rstn),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Clear port has priority; user writes beyond DEPTH are dropped.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = clr_addr_s;
        wr_data_s = INIT_VALUE;
        if (clr_we_s) begin
            wr_en_s = 1'b1;
        end else if (rstn && !busy_s && we && ({1'b0, wa} < DEPTH_W)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = wa;
            wr_data_s = di;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    assign rd_acc_s  = rstn && !busy_s && re;
    assign rd_data_s = ({1'b0, ra_d_r} < DEPTH_W) ? mem[ra_d_r] : {DW{1'b0}};

    // Read address capture and valid strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ra_d_r     <= {AW{1'b0}};
            dout_vld_r <= 1'b0;
        end else begin
            dout_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                ra_d_r <= ra;
            end
        end
    end

`ifdef NV_RAM_RWS_PARAM_OUTREG_EN
    logic [DW-1:0] dout_q_r;
    logic          dout_vld_q_r;

    // Output stage holds the last read word until the next strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_q_r     <= {DW{1'b0}};
            dout_vld_q_r <= 1'b0;
        end else begin
            dout_vld_q_r <= dout_vld_r;
            if (busy_s) begin
                dout_q_r <= {DW{1'b0}};
            end else if (dout_vld_r) begin
                dout_q_r <= rd_data_s;
            end
        end
    end

    assign dout     = dout_q_r;
    assign dout_vld = dout_vld_q_r;
`else
    assign dout     = busy_s ? {DW{1'b0}} : rd_data_s;
    assign dout_vld = dout_vld_r;
`endif

    assign busy = busy_s;

endmodule
